// File: rtl/dcache_store_buffer_if.sv
// Store-buffer interface: M1 enqueue, commit/flush control, cache drain port and load-forward lookups.
// The buffer connects through the slave modport; the M1/cache side uses master.
interface dcache_store_buffer_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LD_PORTS = 1,
  parameter int WAY_W    = 2
) ();
  localparam int NB = DATA_W / 8;

  logic                         flush_i;
  logic                         enq_valid_i;
  logic                         enq_ready_o;
  logic [ADDR_W-1:0]            enq_addr_i;
  logic [DATA_W-1:0]            enq_data_i;
  logic [NB-1:0]                enq_strb_i;
  logic                         enq_uncached_i;
  logic [WAY_W-1:0]             enq_way_i;
  logic                         commit_i;
  logic                         drain_valid_o;
  logic                         drain_ready_i;
  logic [ADDR_W-1:0]            drain_addr_o;
  logic [DATA_W-1:0]            drain_data_o;
  logic [NB-1:0]                drain_strb_o;
  logic                         drain_uncached_o;
  logic [WAY_W-1:0]             drain_way_o;
  logic [LD_PORTS*ADDR_W-1:0]   ld_addr_i;
  logic [LD_PORTS*DATA_W-1:0]   ld_fwd_data_o;
  logic [LD_PORTS*NB-1:0]       ld_fwd_mask_o;
  logic [LD_PORTS-1:0]          ld_uc_hit_o;
  logic                         full_o;
  logic                         empty_o;

  modport slave (
    input  flush_i, enq_valid_i, enq_addr_i, enq_data_i, enq_strb_i, enq_uncached_i,
           enq_way_i, commit_i, drain_ready_i, ld_addr_i,
    output enq_ready_o, drain_valid_o, drain_addr_o, drain_data_o, drain_strb_o,
           drain_uncached_o, drain_way_o, ld_fwd_data_o, ld_fwd_mask_o, ld_uc_hit_o,
           full_o, empty_o
  );

  modport master (
    output flush_i, enq_valid_i, enq_addr_i, enq_data_i, enq_strb_i, enq_uncached_i,
           enq_way_i, commit_i, drain_ready_i, ld_addr_i,
    input  enq_ready_o, drain_valid_o, drain_addr_o, drain_data_o, drain_strb_o,
           drain_uncached_o, drain_way_o, ld_fwd_data_o, ld_fwd_mask_o, ld_uc_hit_o,
           full_o, empty_o
  );
endinterface

// File: rtl/dcache_store_buffer.sv
// In-order store buffer: speculative/committed stores in a circular queue,
// in-order drain of committed entries, byte-merged forwarding to load ports.
module dcache_store_buffer #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LD_PORTS = 1,
  parameter int WAY_W    = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  dcache_store_buffer_if.slave   sb
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(SB_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int OFF_W = $clog2(NB);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     strb;
    logic              uncached;
    logic [WAY_W-1:0]  way;
  } entry_t;

  entry_t            mem_q [SB_DEPTH];
  entry_t            enq_entry;
  entry_t            head_entry;
  logic [PTR_W-1:0]  head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
  logic [PTR_W-1:0]  count;
  logic              full, empty, drain_valid;
  logic              enq_fire, commit_ok, drain_fire;

  logic [LD_PORTS*DATA_W-1:0] fwd_data;
  logic [LD_PORTS*NB-1:0]     fwd_mask;
  logic [LD_PORTS-1:0]        uc_hit;

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  assign count       = tail_q - head_q;
  assign full        = (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]) && (tail_q[IDX_W] != head_q[IDX_W]);
  assign empty       = (tail_q == head_q);
  assign drain_valid = (head_q != cptr_q);

  assign enq_fire   = sb.enq_valid_i && !full && !sb.flush_i;
  assign commit_ok  = sb.commit_i && (cptr_q != tail_q);
  assign drain_fire = drain_valid && sb.drain_ready_i;

  // NOTE: combinational next-state uses blocking '=', the registers below use '<='.
  always_comb begin
    head_d = head_q + PTR_W'(drain_fire);
    cptr_d = cptr_q + PTR_W'(commit_ok);
    tail_d = sb.flush_i ? cptr_d : tail_q + PTR_W'(enq_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
    end
  end

  assign enq_entry = '{addr:     sb.enq_addr_i,
                       data:     sb.enq_data_i,
                       strb:     sb.enq_strb_i,
                       uncached: sb.enq_uncached_i,
                       way:      sb.enq_way_i};

  // NOTE: entry storage has no reset; occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q[IDX_W-1:0]] <= enq_entry;
  end

  assign head_entry = mem_q[head_q[IDX_W-1:0]];

  // Walk oldest to youngest so a younger matching byte overwrites an older one.
  // NOTE: every output is defaulted first so no latch is inferred.
  always_comb begin : fwd_lookup
    logic [PTR_W-1:0]        slot;
    logic [ADDR_W-OFF_W-1:0] ld_word;
    entry_t                  e;
    fwd_data = '0;
    fwd_mask = '0;
    uc_hit   = '0;
    slot     = '0;
    ld_word  = '0;
    e        = '0;
    for (int p = 0; p < LD_PORTS; p++) begin
      ld_word = sb.ld_addr_i[p*ADDR_W+OFF_W +: ADDR_W-OFF_W];
      for (int i = 0; i < SB_DEPTH; i++) begin
        slot = head_q + PTR_W'(i);
        e    = mem_q[slot[IDX_W-1:0]];
        if ((PTR_W'(i) < count) && (e.addr[ADDR_W-1:OFF_W] == ld_word)) begin
          if (e.uncached) begin
            uc_hit[p] = 1'b1;
          end else begin
            for (int b = 0; b < NB; b++) begin
              if (e.strb[b]) begin
                fwd_data[(p*NB+b)*8 +: 8] = e.data[b*8 +: 8];
                fwd_mask[p*NB+b]          = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign sb.enq_ready_o      = !full;
  assign sb.full_o           = full;
  assign sb.empty_o          = empty;
  assign sb.drain_valid_o    = drain_valid;
  assign sb.drain_addr_o     = head_entry.addr;
  assign sb.drain_data_o     = head_entry.data;
  assign sb.drain_strb_o     = head_entry.strb;
  assign sb.drain_uncached_o = head_entry.uncached;
  assign sb.drain_way_o      = head_entry.way;
  assign sb.ld_fwd_data_o    = fwd_data;
  assign sb.ld_fwd_mask_o    = fwd_mask;
  assign sb.ld_uc_hit_o      = uc_hit;

  // A commit with nothing left to commit is a pipeline bug upstream; it is ignored here.
  commit_has_target: assert property (@(posedge clk) disable iff (!rst_n)
                                      sb.commit_i |-> (cptr_q != tail_q))
    else $warning("store buffer: commit with no uncommitted entry ignored");
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Randomized scoreboard bench for dcache_store_buffer: queue-based reference model,
// per-cycle expectations and committed-store drain order checked by a monitor.
module tb_dcache_store_buffer;
  localparam int SB_DEPTH = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int LD_PORTS = 2;
  localparam int WAY_W    = 2;
  localparam int NB       = DATA_W / 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        uc;
    logic [1:0]  way;
  } st_t;

  typedef struct {
    logic        full;
    logic        empty;
    logic        ready;
    logic        dv;
    logic [63:0] fdata;
    logic [7:0]  mask;
    logic [1:0]  uc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LD_PORTS(LD_PORTS), .WAY_W(WAY_W)) sb_if ();

  dcache_store_buffer #(
    .SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LD_PORTS(LD_PORTS), .WAY_W(WAY_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  st_t  mq[$];           // model contents, oldest first
  int   ncomm;           // number of committed entries at the front of mq
  bit   model_ok = 1'b0;
  st_t  exp_drain_q[$];  // committed stores in the order they must drain
  exp_t rec_q[$];        // per-cycle expected status/forwarding
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit ev, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit uc, input logic [1:0] w, input bit cm, input bit fl, input bit rdy,
                       input logic [31:0] l0, input logic [31:0] l1);
    sb_if.enq_valid_i    = ev;
    sb_if.enq_addr_i     = a;
    sb_if.enq_data_i     = d;
    sb_if.enq_strb_i     = s;
    sb_if.enq_uncached_i = uc;
    sb_if.enq_way_i      = w;
    sb_if.commit_i       = cm;
    sb_if.flush_i        = fl;
    sb_if.drain_ready_i  = rdy;
    sb_if.ld_addr_i      = {l1, l0};
  endtask

  task automatic idle(input bit rdy, input logic [31:0] l0, input logic [31:0] l1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, rdy, l0, l1);
  endtask

  // Expected outputs from the model: youngest matching store wins per byte.
  function automatic exp_t model_expect();
    exp_t        e;
    logic [31:0] ld;
    int          sz;
    sz      = mq.size();
    e.full  = (sz == SB_DEPTH);
    e.empty = (sz == 0);
    e.ready = (sz != SB_DEPTH);
    e.dv    = (ncomm > 0);
    e.fdata = '0;
    e.mask  = '0;
    e.uc    = '0;
    for (int p = 0; p < LD_PORTS; p++) begin
      ld = sb_if.ld_addr_i[p*32 +: 32];
      for (int k = 0; k < sz; k++)
        if (mq[k].uc && mq[k].addr[31:2] == ld[31:2]) e.uc[p] = 1'b1;
      for (int b = 0; b < NB; b++) begin
        for (int k = sz - 1; k >= 0; k--) begin
          if (!mq[k].uc && mq[k].addr[31:2] == ld[31:2] && mq[k].strb[b]) begin
            e.fdata[p*32 + b*8 +: 8] = mq[k].data[b*8 +: 8];
            e.mask[p*4 + b]          = 1'b1;
            break;
          end
        end
      end
    end
    return e;
  endfunction

  function automatic void model_update();
    st_t n;
    bit  enq, cmt, drn;
    if (!rst_n) begin
      mq.delete();
      exp_drain_q.delete();
      ncomm    = 0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    enq = sb_if.enq_valid_i && (mq.size() < SB_DEPTH) && !sb_if.flush_i;
    cmt = sb_if.commit_i && (ncomm < mq.size());
    drn = sb_if.drain_ready_i && (ncomm > 0);
    if (cmt) begin
      exp_drain_q.push_back(mq[ncomm]);
      ncomm++;
    end
    if (drn) begin
      void'(mq.pop_front());
      ncomm--;
    end
    if (sb_if.flush_i)
      while (mq.size() > ncomm) void'(mq.pop_back());
    if (enq) begin
      n.addr = sb_if.enq_addr_i;
      n.data = sb_if.enq_data_i;
      n.strb = sb_if.enq_strb_i;
      n.uc   = sb_if.enq_uncached_i;
      n.way  = sb_if.enq_way_i;
      mq.push_back(n);
    end
  endfunction

  task automatic half1();
    if (model_ok) rec_q.push_back(model_expect());
    @(negedge clk);
  endtask

  task automatic half2();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    half1();
    half2();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(0, 0, 0);
    cycle();
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per cycle and one committed store per drain handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    st_t  d;
    if (rec_q.size() > 0) begin
      e = rec_q.pop_front();
      check("full_o",        sb_if.full_o,        e.full);
      check("empty_o",       sb_if.empty_o,       e.empty);
      check("enq_ready_o",   sb_if.enq_ready_o,   e.ready);
      check("drain_valid_o", sb_if.drain_valid_o, e.dv);
      check("ld_fwd_mask_o", sb_if.ld_fwd_mask_o, e.mask);
      check("ld_fwd_data_o", sb_if.ld_fwd_data_o, e.fdata);
      check("ld_uc_hit_o",   sb_if.ld_uc_hit_o,   e.uc);
      if (sb_if.drain_valid_o && sb_if.drain_ready_i) begin
        if (exp_drain_q.size() == 0) begin
          check("unexpected_drain", 1, 0);
        end else begin
          d = exp_drain_q.pop_front();
          check("drain_addr_o",     sb_if.drain_addr_o,     d.addr);
          check("drain_data_o",     sb_if.drain_data_o,     d.data);
          check("drain_strb_o",     sb_if.drain_strb_o,     d.strb);
          check("drain_uncached_o", sb_if.drain_uncached_o, d.uc);
          check("drain_way_o",      sb_if.drain_way_o,      d.way);
        end
      end
    end
  end

  function automatic logic [31:0] rnd_addr();
    logic [31:0] words [4];
    words[0] = 32'h100; words[1] = 32'h104; words[2] = 32'h200; words[3] = 32'h204;
    return words[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0;
    ncomm = 0;
    idle(0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Reset state, then fill with uncommitted stores
    idle(1, 32'h100, 32'h100);
    half1();
    check("rst_empty",  sb_if.empty_o,       1);
    check("rst_full",   sb_if.full_o,        0);
    check("rst_ready",  sb_if.enq_ready_o,   1);
    check("rst_dvalid", sb_if.drain_valid_o, 0);
    check("rst_mask",   sb_if.ld_fwd_mask_o, 0);
    check("rst_uchit",  sb_if.ld_uc_hit_o,   0);
    half2();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40 + 32'(i*4), $urandom, 4'hF, 0, 2'(i), 0, 0, 1, 0, 0);
      cycle();
    end
    idle(1, 0, 0);
    half1();
    check("fill_full",   sb_if.full_o,        1);
    check("fill_ready",  sb_if.enq_ready_o,   0);
    check("fill_dvalid", sb_if.drain_valid_o, 0);
    half2();
    do_reset();

    // Byte merge; the same-cycle enqueue must not forward
    drive(1, 32'h100, 32'h11223344, 4'b0011, 0, 0, 0, 0, 0, 32'h100, 0);
    cycle();
    drive(1, 32'h100, 32'hAABBCCDD, 4'b0110, 0, 1, 0, 0, 0, 32'h100, 0);
    half1();
    check("merge_sameenq_mask", sb_if.ld_fwd_mask_o[3:0], 4'b0011);
    half2();
    idle(0, 32'h100, 0);
    half1();
    check("merge_mask", sb_if.ld_fwd_mask_o[3:0],  4'b0111);
    check("merge_data", sb_if.ld_fwd_data_o[31:0], 32'h00BBCC44);
    half2();
    do_reset();

    // Commit one plus flush in the same cycle keeps only entry 0
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i*4), 32'hC0DE0000 + 32'(i), 4'hF, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle();
    idle(0, 32'h304, 32'h308);
    half1();
    check("flush_empty",  sb_if.empty_o,       0);
    check("flush_dvalid", sb_if.drain_valid_o, 1);
    check("flush_daddr",  sb_if.drain_addr_o,  32'h300);
    check("flush_gone",   sb_if.ld_fwd_mask_o, 0);
    half2();
    idle(1, 0, 0);
    cycle();
    idle(0, 0, 0);
    half1();
    check("flush_drained_empty", sb_if.empty_o, 1);
    half2();
    do_reset();

    // Full buffer, commit all, stream drains with enqueue held
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h400 + 32'(i*4), $urandom, 4'hF, 0, 2'(i), 0, 0, 0, 0, 0);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h500 + 32'(i*4), $urandom, 4'hF, 0, 0, 1, 0, 0, 0, 0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h600 + 32'(i*4), $urandom, 4'($urandom), 0, 2'(i), ncomm < mq.size(), 0, 1, 32'h604, 0);
      half1();
      if (i == 0) check("stream_first_ready",  sb_if.enq_ready_o, 0);
      if (i == 1) check("stream_second_ready", sb_if.enq_ready_o, 1);
      half2();
    end
    do_reset();

    // Uncached store seen only by port 1
    drive(1, 32'h200, 32'h12345678, 4'hF, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    idle(0, 32'h300, 32'h200);
    half1();
    check("uc_hit",  sb_if.ld_uc_hit_o,   2'b10);
    check("uc_mask", sb_if.ld_fwd_mask_o, 0);
    half2();
    do_reset();

    // Reset in the middle of draining committed stores
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h700 + 32'(i*4), $urandom, 4'hF, 0, 0, i > 0, 0, 0, 0, 0);
      cycle();
    end
    idle(1, 0, 0);
    sb_if.commit_i = 1'b1;
    cycle();
    rst_n = 1'b0;
    idle(1, 0, 0);
    cycle();
    rst_n = 1'b1;
    idle(1, 0, 0);
    half1();
    check("rst_mid_drain_empty",  sb_if.empty_o,       1);
    check("rst_mid_drain_dvalid", sb_if.drain_valid_o, 0);
    half2();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) != 0, rnd_addr(), $urandom, 4'($urandom), $urandom_range(0, 7) == 0,
            2'($urandom), (ncomm < mq.size()) && ($urandom_range(0, 1) != 0),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, rnd_addr(), rnd_addr());
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
      rst_n = 1'b1;
    end

    // Commit and drain whatever remains, with a bounded cycle budget
    for (int i = 0; i < 40 && mq.size() > 0; i++) begin
      drive(0, 0, 0, 0, 0, 0, ncomm < mq.size(), 0, 1, 0, 0);
      cycle();
    end
    check("final_model_empty",  mq.size(), 0);
    check("final_drain_budget", exp_drain_q.size(), 0);
    idle(0, 0, 0);
    half1();
    check("final_empty", sb_if.empty_o, 1);
    half2();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
